// File: rtl/ip_hdr_pkg.sv
// Shared types for the IP transmit header arbiter.
package ip_hdr_pkg;

    localparam int unsigned IP_HDR_W = 104;

    localparam logic [7:0] DEFAULT_TTL_C = 8'd64;

    typedef struct packed {
        logic [5:0]  dscp;
        logic [1:0]  ecn;
        logic [15:0] length;
        logic [7:0]  ttl;
        logic [7:0]  protocol;
        logic [31:0] source_ip;
        logic [31:0] dest_ip;
    } ip_hdr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        LOCK = 2'd2
    } arb_state_t;

endpackage

// File: rtl/ip_header_arb_rr_arbiter.sv
// Request arbiter: round-robin from a rotating pointer, or fixed priority.
module rr_arbiter #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned ARB_MODE = 0,
    localparam int unsigned IDX_W   = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              sync_rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              advance,
    output logic [IDX_W-1:0]  grant_idx_c,
    output logic              grant_valid_c
);

    logic [IDX_W-1:0] ptr;

    // First requester found scanning from the pointer (or from 0 in fixed mode).
    always_comb begin
        int unsigned cand;
        grant_idx_c   = '0;
        grant_valid_c = 1'b0;
        cand          = 0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cand = (ARB_MODE == 0) ? ((32'(ptr) + i) % NUM_CH) : i;
            if (!grant_valid_c && req[IDX_W'(cand)]) begin
                grant_valid_c = 1'b1;
                grant_idx_c   = IDX_W'(cand);
            end
        end
    end

    // Pointer moves to the channel after the winner on every accepted grant.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            ptr <= '0;
        end else if (advance && grant_valid_c) begin
            ptr <= (grant_idx_c == IDX_W'(NUM_CH - 1)) ? '0 : grant_idx_c + IDX_W'(1);
        end
    end

endmodule

// File: rtl/ip_header_arb.sv
// N-channel IP header arbiter with a single registered output slot.
module ip_header_arb
    import ip_hdr_pkg::*;
#(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned ARB_MODE     = 0,
    parameter int unsigned LOCK_EN      = 1,
    parameter int unsigned TTL_OVERRIDE = 0,
    parameter logic [7:0]  DEFAULT_TTL  = DEFAULT_TTL_C,
    localparam int unsigned CH_W        = $clog2(NUM_CH)
) (
    input  logic                       clk,
    input  logic                       sync_rst,
    input  logic [NUM_CH-1:0]          in_hdr_valid,
    output logic [NUM_CH-1:0]          in_hdr_ready,
    input  logic [NUM_CH*IP_HDR_W-1:0] in_hdr,
    output logic                       out_hdr_valid,
    input  logic                       out_hdr_ready,
    output ip_hdr_t                    out_hdr,
    output logic [CH_W-1:0]            out_ch,
    input  logic                       lock_release,
    output logic                       busy
);

    arb_state_t      state;
    logic [CH_W-1:0] grant_idx;
    logic            grant_valid;
    logic            advance;
    ip_hdr_t         hdr_sel;
    ip_hdr_t         hdr_cap;

    assign advance = (state == IDLE);

    rr_arbiter #(
        .NUM_CH   (NUM_CH),
        .ARB_MODE (ARB_MODE)
    ) u_arb (
        .clk           (clk),
        .sync_rst      (sync_rst),
        .req           (in_hdr_valid),
        .advance       (advance),
        .grant_idx_c   (grant_idx),
        .grant_valid_c (grant_valid)
    );

    // Winner's header, with a zero TTL replaced when override is enabled.
    always_comb begin
        hdr_sel = in_hdr[grant_idx*IP_HDR_W +: IP_HDR_W];
        hdr_cap = hdr_sel;
        if (TTL_OVERRIDE == 1 && hdr_sel.ttl == 8'd0) begin
            hdr_cap.ttl = DEFAULT_TTL;
        end
    end

    // Accept only the winner, only while idle and out of reset.
    always_comb begin
        in_hdr_ready = '0;
        if (state == IDLE && grant_valid && !sync_rst) begin
            in_hdr_ready[grant_idx] = 1'b1;
        end
    end

    // Control FSM and registered output slot.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state         <= IDLE;
            out_hdr       <= '0;
            out_ch        <= '0;
            out_hdr_valid <= 1'b0;
            busy          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        out_hdr       <= hdr_cap;
                        out_ch        <= grant_idx;
                        out_hdr_valid <= 1'b1;
                        busy          <= 1'b1;
                        state         <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_hdr_ready) begin
                        out_hdr_valid <= 1'b0;
                        if (LOCK_EN == 1) begin
                            state <= LOCK;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                LOCK: begin
                    if (lock_release) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    out_hdr_valid <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ip_header_arb.sv
// Directed bench: instance A round-robin/no lock/TTL override, instance B fixed priority/lock.
module tb_ip_header_arb;
    import ip_hdr_pkg::*;

    localparam int unsigned NCH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Instance A signals
    logic                    rst_a;
    logic [NCH-1:0]          vld_a, rdy_a;
    logic [NCH*IP_HDR_W-1:0] hdr_a;
    logic                    ov_a, or_a, lr_a, busy_a;
    ip_hdr_t                 oh_a;
    logic [1:0]              ch_a;

    // Instance B signals
    logic                    rst_b;
    logic [NCH-1:0]          vld_b, rdy_b;
    logic [NCH*IP_HDR_W-1:0] hdr_b;
    logic                    ov_b, or_b, lr_b, busy_b;
    ip_hdr_t                 oh_b;
    logic [1:0]              ch_b;

    ip_header_arb #(
        .NUM_CH(NCH), .ARB_MODE(0), .LOCK_EN(0), .TTL_OVERRIDE(1), .DEFAULT_TTL(8'd64)
    ) dut_a (
        .clk(clk), .sync_rst(rst_a), .in_hdr_valid(vld_a), .in_hdr_ready(rdy_a),
        .in_hdr(hdr_a), .out_hdr_valid(ov_a), .out_hdr_ready(or_a), .out_hdr(oh_a),
        .out_ch(ch_a), .lock_release(lr_a), .busy(busy_a)
    );

    ip_header_arb #(
        .NUM_CH(NCH), .ARB_MODE(1), .LOCK_EN(1), .TTL_OVERRIDE(0), .DEFAULT_TTL(8'd64)
    ) dut_b (
        .clk(clk), .sync_rst(rst_b), .in_hdr_valid(vld_b), .in_hdr_ready(rdy_b),
        .in_hdr(hdr_b), .out_hdr_valid(ov_b), .out_hdr_ready(or_b), .out_hdr(oh_b),
        .out_ch(ch_b), .lock_release(lr_b), .busy(busy_b)
    );

    typedef struct {
        logic [3:0] vld;
        logic       ordy;
        logic       lrel;
        logic [3:0] e_rdy;
        logic       e_ov;
        logic [1:0] e_ch;
        logic       e_busy;
    } vec_t;

    vec_t va [10];
    vec_t vb [12];

    function automatic ip_hdr_t mk_hdr(input int ch);
        ip_hdr_t h;
        h.dscp      = 6'(ch + 1);
        h.ecn       = 2'(ch);
        h.length    = 16'(100 + ch);
        h.ttl       = (ch == 2) ? 8'd0 : 8'(5 + ch);
        h.protocol  = 8'd17;
        h.source_ip = 32'h0A00_0000 + 32'(ch);
        h.dest_ip   = (ch == 2) ? 32'hC0A8_0001 : 32'h0B00_0000 + 32'(ch);
        return h;
    endfunction

    // Expected output of instance A: zero TTL becomes 64.
    function automatic ip_hdr_t exp_a(input int ch);
        ip_hdr_t h;
        h = mk_hdr(ch);
        if (h.ttl == 8'd0) h.ttl = 8'd64;
        return h;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < NCH; i++) begin
            hdr_a[i*IP_HDR_W +: IP_HDR_W] = mk_hdr(i);
            hdr_b[i*IP_HDR_W +: IP_HDR_W] = mk_hdr(i);
        end
        // Round-robin, all valid, downstream always ready
        va[0] = '{4'hF, 1'b1, 1'b0, 4'h1, 1'b0, 2'd0, 1'b0};
        va[1] = '{4'hF, 1'b1, 1'b0, 4'h0, 1'b1, 2'd0, 1'b1};
        va[2] = '{4'hF, 1'b1, 1'b0, 4'h2, 1'b0, 2'd0, 1'b0};
        va[3] = '{4'hF, 1'b1, 1'b0, 4'h0, 1'b1, 2'd1, 1'b1};
        va[4] = '{4'hF, 1'b1, 1'b0, 4'h4, 1'b0, 2'd1, 1'b0};
        va[5] = '{4'hF, 1'b1, 1'b0, 4'h0, 1'b1, 2'd2, 1'b1};
        va[6] = '{4'hF, 1'b1, 1'b0, 4'h8, 1'b0, 2'd2, 1'b0};
        va[7] = '{4'hF, 1'b1, 1'b0, 4'h0, 1'b1, 2'd3, 1'b1};
        va[8] = '{4'hF, 1'b1, 1'b0, 4'h1, 1'b0, 2'd3, 1'b0};
        va[9] = '{4'hF, 1'b1, 1'b0, 4'h0, 1'b1, 2'd0, 1'b1};
        // Fixed priority with lock, channels 1 and 3 valid
        vb[0]  = '{4'hA, 1'b1, 1'b0, 4'h2, 1'b0, 2'd0, 1'b0};
        vb[1]  = '{4'hA, 1'b1, 1'b1, 4'h0, 1'b1, 2'd1, 1'b1};
        vb[2]  = '{4'hA, 1'b1, 1'b0, 4'h0, 1'b0, 2'd1, 1'b1};
        vb[3]  = '{4'hA, 1'b1, 1'b0, 4'h0, 1'b0, 2'd1, 1'b1};
        vb[4]  = '{4'hA, 1'b1, 1'b0, 4'h0, 1'b0, 2'd1, 1'b1};
        vb[5]  = '{4'hA, 1'b1, 1'b0, 4'h0, 1'b0, 2'd1, 1'b1};
        vb[6]  = '{4'hA, 1'b1, 1'b0, 4'h0, 1'b0, 2'd1, 1'b1};
        vb[7]  = '{4'hA, 1'b1, 1'b1, 4'h0, 1'b0, 2'd1, 1'b1};
        vb[8]  = '{4'hA, 1'b1, 1'b1, 4'h2, 1'b0, 2'd1, 1'b0};
        vb[9]  = '{4'hA, 1'b1, 1'b0, 4'h0, 1'b1, 2'd1, 1'b1};
        vb[10] = '{4'hA, 1'b1, 1'b1, 4'h0, 1'b0, 2'd1, 1'b1};
        vb[11] = '{4'hA, 1'b0, 1'b0, 4'h2, 1'b0, 2'd1, 1'b0};

        // Reset both instances with requests pending
        rst_a = 1'b1; vld_a = 4'hF; or_a = 1'b0; lr_a = 1'b0;
        rst_b = 1'b1; vld_b = 4'hF; or_b = 1'b0; lr_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst A ready", 128'(rdy_a), 128'h0);
        chk("rst A valid", 128'(ov_a), 128'h0);
        chk("rst A busy", 128'(busy_a), 128'h0);
        chk("rst A hdr", 128'(oh_a), 128'h0);
        chk("rst A ch", 128'(ch_a), 128'h0);
        chk("rst B ready", 128'(rdy_b), 128'h0);
        chk("rst B valid", 128'(ov_b), 128'h0);
        vld_a = 4'h0; vld_b = 4'h0;
        @(negedge clk);
        rst_a = 1'b0;

        // Instance A table
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vld_a = va[i].vld; or_a = va[i].ordy; lr_a = va[i].lrel;
            #1;
            chk($sformatf("A[%0d] ready", i), 128'(rdy_a), 128'(va[i].e_rdy));
            chk($sformatf("A[%0d] valid", i), 128'(ov_a), 128'(va[i].e_ov));
            chk($sformatf("A[%0d] ch", i), 128'(ch_a), 128'(va[i].e_ch));
            chk($sformatf("A[%0d] busy", i), 128'(busy_a), 128'(va[i].e_busy));
            if (va[i].e_ov) chk($sformatf("A[%0d] hdr", i), 128'(oh_a), 128'(exp_a(int'(va[i].e_ch))));
        end

        // Instance B table
        @(negedge clk);
        rst_b = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            vld_b = vb[i].vld; or_b = vb[i].ordy; lr_b = vb[i].lrel;
            #1;
            chk($sformatf("B[%0d] ready", i), 128'(rdy_b), 128'(vb[i].e_rdy));
            chk($sformatf("B[%0d] valid", i), 128'(ov_b), 128'(vb[i].e_ov));
            chk($sformatf("B[%0d] ch", i), 128'(ch_b), 128'(vb[i].e_ch));
            chk($sformatf("B[%0d] busy", i), 128'(busy_b), 128'(vb[i].e_busy));
            if (vb[i].e_ov) chk($sformatf("B[%0d] hdr", i), 128'(oh_b), 128'(mk_hdr(int'(vb[i].e_ch))));
        end

        // Instance A: fresh reset, grant ch2 (zero TTL) then hold under backpressure
        @(negedge clk);
        rst_a = 1'b1; vld_a = 4'h0; or_a = 1'b0;
        @(negedge clk);
        rst_a = 1'b0;
        @(negedge clk);
        vld_a = 4'h4;
        #1;
        chk("bp grant ready", 128'(rdy_a), 128'h4);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            vld_a = 4'hF;
            #1;
            chk($sformatf("bp[%0d] ready", k), 128'(rdy_a), 128'h0);
            chk($sformatf("bp[%0d] valid", k), 128'(ov_a), 128'h1);
            chk($sformatf("bp[%0d] ch", k), 128'(ch_a), 128'h2);
            chk($sformatf("bp[%0d] hdr", k), 128'(oh_a), 128'(exp_a(2)));
        end
        chk("ttl default", 128'(oh_a.ttl), 128'd64);
        chk("dest kept", 128'(oh_a.dest_ip), 128'hC0A8_0001);

        // Reset mid-HOLD with pointer at 3; next grant must be ch0
        @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        #1;
        chk("rst hold valid", 128'(ov_a), 128'h0);
        chk("rst hold hdr", 128'(oh_a), 128'h0);
        chk("rst hold ch", 128'(ch_a), 128'h0);
        chk("rst hold busy", 128'(busy_a), 128'h0);
        chk("rst hold ready ch0", 128'(rdy_a), 128'h1);
        @(negedge clk);
        #1;
        chk("after rst valid", 128'(ov_a), 128'h1);
        chk("after rst ch", 128'(ch_a), 128'h0);
        chk("after rst hdr ttl5", 128'(oh_a.ttl), 128'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
